// File: rtl/reg_bank.sv
// Dual-read-port register bank with bitwise write ops and a one-register-per-cycle
// clear sweep; all read data is registered, and writes that cannot be taken raise err.
module reg_bank #(
    parameter int ADDR_W = 3,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] A,
    input  logic [WIDTH-1:0]  data,
    input  logic              clear_all,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [WIDTH-1:0]  q0,
    output logic [WIDTH-1:0]  q1,
    output logic              busy,
    output logic              wr_ack,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } state_e;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    state_e           state_q, state_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             wr_ack_q, wr_ack_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] q0_q, q0_d;
    logic [WIDTH-1:0] q1_q, q1_d;

    function automatic logic [WIDTH-1:0] apply_op(input op_e op,
                                                  input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] msk);
        logic [WIDTH-1:0] res;
        case (op)
            OP_LOAD:   res = msk;
            OP_SET:    res = cur | msk;
            OP_CLEAR:  res = cur & ~msk;
            OP_TOGGLE: res = cur ^ msk;
            default:   res = cur;
        endcase
        return res;
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        regs_d   = regs_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        wr_ack_d = 1'b0;
        err_d    = 1'b0;
        // Read data comes from the pre-edge array, so a same-cycle write reads old.
        q0_d     = regs_q[ra0];
        q1_d     = regs_q[ra1];

        case (state_q)
            S_IDLE: begin
                if (clear_all) begin
                    state_d = S_SWEEP;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    err_d   = write;
                end else if (write) begin
                    wr_ack_d = 1'b1;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (A == ADDR_W'(i)) begin
                            regs_d[i] = apply_op(op_e'(mode), regs_q[i], data);
                        end
                    end
                end
            end
            S_SWEEP: begin
                // clear_all is deliberately ignored here; the sweep never restarts.
                regs_d[cnt_q[ADDR_W-1:0]] = '0;
                err_d = write;
                cnt_d = cnt_q + (ADDR_W + 1)'(1);
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is reset explicitly because reset must zero every register.
            regs_q   <= '{default: '0};
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            wr_ack_q <= 1'b0;
            err_q    <= 1'b0;
            q0_q     <= '0;
            q1_q     <= '0;
        end else begin
            regs_q   <= regs_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            wr_ack_q <= wr_ack_d;
            err_q    <= err_d;
            q0_q     <= q0_d;
            q1_q     <= q1_d;
        end
    end

    assign q0     = q0_q;
    assign q1     = q1_q;
    assign busy   = busy_q;
    assign wr_ack = wr_ack_q;
    assign err    = err_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: load/bit ops, read-old, sweep,
// write/clear collision and reset during a sweep.
module tb_reg_bank;

    localparam logic [1:0] M_LOAD = 2'b00;
    localparam logic [1:0] M_SET  = 2'b01;
    localparam logic [1:0] M_CLR  = 2'b10;
    localparam logic [1:0] M_TGL  = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       write;
    logic [1:0] mode;
    logic [2:0] A;
    logic [7:0] data;
    logic       clear_all;
    logic [2:0] ra0, ra1;
    logic [7:0] q0, q1;
    logic       busy, wr_ack, err;

    logic [7:0] model [8];
    int         n_checks = 0;
    int         n_pass   = 0;

    reg_bank #(.ADDR_W(3), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .write(write), .mode(mode), .A(A), .data(data),
        .clear_all(clear_all), .ra0(ra0), .ra1(ra1), .q0(q0), .q1(q1),
        .busy(busy), .wr_ack(wr_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] m, input logic [2:0] a, input logic [7:0] d);
        write = 1'b1; mode = m; A = a; data = d;
        tick();
        write = 1'b0;
        check($sformatf("wr_ack a=%0d", a), wr_ack, 1);
        check($sformatf("no_err a=%0d", a), err, 0);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            ra0 = 3'(i);
            ra1 = 3'(7 - i);
            tick();
            check($sformatf("%s q0[%0d]", tag, i), q0, model[i]);
            check($sformatf("%s q1[%0d]", tag, 7 - i), q1, model[7 - i]);
        end
    endtask

    initial begin
        int blen;
        reset = 1'b1; write = 1'b0; mode = M_LOAD; A = '0; data = '0;
        clear_all = 1'b0; ra0 = '0; ra1 = '0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst wr_ack", wr_ack, 0);
        check("rst err", err, 0);
        check("rst q0", q0, 0);
        check("rst q1", q1, 0);
        #2 reset = 1'b0;

        // Load on the first edge after reset release, then read it back.
        do_write(M_LOAD, 3'd5, 8'hA5); model[5] = 8'hA5;
        ra0 = 3'd5;
        tick();
        check("wr_ack one cycle", wr_ack, 0);
        check("load q0", q0, 8'hA5);

        // Bit operations on reg[2].
        do_write(M_LOAD, 3'd2, 8'hF0); model[2] = 8'hF0;
        do_write(M_SET, 3'd2, 8'h0F);  model[2] = 8'hFF;
        ra0 = 3'd2; tick(); check("set q0", q0, 8'hFF);
        do_write(M_CLR, 3'd2, 8'h81);  model[2] = 8'h7E;
        ra0 = 3'd2; tick(); check("clear q0", q0, 8'h7E);
        do_write(M_TGL, 3'd2, 8'hFF);  model[2] = 8'h81;
        ra0 = 3'd2; tick(); check("toggle q0", q0, 8'h81);
        check_all("bitops");

        // Read-old on a same-cycle write.
        do_write(M_LOAD, 3'd3, 8'h11); model[3] = 8'h11;
        write = 1'b1; mode = M_LOAD; A = 3'd3; data = 8'h22; ra1 = 3'd3;
        tick();
        write = 1'b0; model[3] = 8'h22;
        check("readold q1", q1, 8'h11);
        check("readold wr_ack", wr_ack, 1);
        tick();
        check("readnew q1", q1, 8'h22);

        // Both ports on the same address.
        ra0 = 3'd5; ra1 = 3'd5;
        tick();
        check("same addr q0", q0, 8'hA5);
        check("same addr q1", q1, 8'hA5);

        // Sweep with a dropped write in cycle 3 and an ignored clear_all in cycle 5.
        do_write(M_LOAD, 3'd0, 8'h11); model[0] = 8'h11;
        do_write(M_LOAD, 3'd1, 8'h22); model[1] = 8'h22;
        do_write(M_LOAD, 3'd2, 8'h33); model[2] = 8'h33;
        do_write(M_LOAD, 3'd3, 8'h44); model[3] = 8'h44;
        do_write(M_LOAD, 3'd4, 8'h55); model[4] = 8'h55;
        do_write(M_LOAD, 3'd5, 8'h66); model[5] = 8'h66;
        do_write(M_LOAD, 3'd6, 8'h77); model[6] = 8'h77;
        do_write(M_LOAD, 3'd7, 8'h88); model[7] = 8'h88;
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("sweep busy c%0d", c), busy, 1);
            ra0 = 3'(c);
            ra1 = (c > 0) ? 3'(c - 1) : 3'd0;
            write = (c == 3);
            mode = M_LOAD; A = 3'd6; data = 8'hEE;
            clear_all = (c == 5);
            tick();
            write = 1'b0; clear_all = 1'b0;
            check($sformatf("sweep old q0 c%0d", c), q0, model[c]);
            if (c > 0) check($sformatf("sweep cleared q1 c%0d", c), q1, 0);
            check($sformatf("sweep err c%0d", c), err, (c == 3) ? 1 : 0);
            check($sformatf("sweep wr_ack c%0d", c), wr_ack, 0);
        end
        check("sweep done busy", busy, 0);
        tick();
        check("sweep no restart", busy, 0);
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        check_all("sweep");

        // Write and clear_all together in IDLE.
        do_write(M_LOAD, 3'd1, 8'h5A); model[1] = 8'h5A;
        do_write(M_LOAD, 3'd6, 8'hC3); model[6] = 8'hC3;
        write = 1'b1; mode = M_LOAD; A = 3'd1; data = 8'hFF; clear_all = 1'b1;
        tick();
        write = 1'b0; clear_all = 1'b0;
        check("collide err", err, 1);
        check("collide wr_ack", wr_ack, 0);
        check("collide busy", busy, 1);
        blen = 1;
        while (busy && blen < 20) begin
            tick();
            if (busy) blen++;
        end
        check("collide busy len", blen, 8);
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        check_all("collide");

        // Reset asserted during sweep cycle 4.
        do_write(M_LOAD, 3'd1, 8'h42); model[1] = 8'h42;
        do_write(M_LOAD, 3'd7, 8'h99); model[7] = 8'h99;
        ra0 = 3'd7; ra1 = 3'd1;
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        repeat (4) tick();
        check("presrst busy", busy, 1);
        check("presrst q0", q0, 8'h99);
        check("presrst q1", q1, 0);
        #2 reset = 1'b1;
        #1;
        check("arst busy", busy, 0);
        check("arst q0", q0, 0);
        check("arst q1", q1, 0);
        check("arst wr_ack", wr_ack, 0);
        check("arst err", err, 0);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        do_write(M_LOAD, 3'd7, 8'h3C); model[7] = 8'h3C;
        check("post rst busy", busy, 0);
        check_all("postrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
